mem_dp: RTL and testbench
=========================

Name: mem_dp

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the single-write/single-read `mem` block.
- Each of its two ports (A, B) can read or write on every cycle.
- Read-during-write behaviour is selectable, and same-address write collisions are arbitrated and flagged.
- An optional hardware clear sequencer zeroes the whole array after reset.
- Used as the shared instruction/data store between the CPU datapath and the I/O or VGA side.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH words.
- RDW_MODE, 0: read-during-write to the same address. 0 = old data (read-first); 1 = new data (write-first).
- CLEAR_ON_RESET, 1: 1 = zero every location after reset; 0 = contents survive reset.

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge.
- reset  in  1  synchronous, active-high reset.
- a_data  in  DATA_WIDTH  port A write data.
- a_addr  in  ADDR_WIDTH  port A address.
- a_we  in  1  port A write enable.
- a_q  out  DATA_WIDTH  port A registered read data.
- b_data  in  DATA_WIDTH  port B write data.
- b_addr  in  ADDR_WIDTH  port B address.
- b_we  in  1  port B write enable.
- b_q  out  DATA_WIDTH  port B registered read data.
- busy  out  1  high while the clear sequence runs; ports are ignored.
- collision  out  1  one-cycle pulse: both ports wrote the same address on the previous edge.

Behaviour:
- Reset (any edge with reset=1):
  - a_q=0, b_q=0, collision=0, clear counter=0.
  - State <= CLEAR if CLEAR_ON_RESET=1, else READY.
  - Reset takes priority over everything, including mid-clear: the counter restarts at 0.
- States: CLEAR and READY. busy = (state==CLEAR).
- CLEAR state, each edge:
  - mem[cnt] <= 0; cnt <= cnt+1.
  - When cnt == 2**ADDR_WIDTH-1, state <= READY.
  - busy is therefore high for exactly 2**ADDR_WIDTH edges after reset deasserts.
  - a_we/b_we are ignored; a_q/b_q are held at 0.
- READY state:
  - Read latency is 1 cycle: x_q on edge N+1 reflects x_addr sampled on edge N.
  - Reads happen every cycle regardless of x_we.
  - A write updates mem[x_addr] on the edge where x_we=1.
- Same-port read-during-write (x_we=1):
  - RDW_MODE=0: x_q = old contents.
  - RDW_MODE=1: x_q = x_data.
- Cross-port (A writes address K while B reads K, or vice versa): same rule as RDW_MODE.
  - Mode 0: the reader gets old data.
  - Mode 1: the reader gets the writer's data.
- Collision (a_we & b_we & a_addr==b_addr):
  - Port A wins: mem[K] <= a_data.
  - collision=1 for the following cycle only.
  - With RDW_MODE=1, both a_q and b_q return a_data.
  - Different addresses with both writes enabled: both writes land, no flag.
- Address wrap: full ADDR_WIDTH decode, no out-of-range addresses. The clear counter is ADDR_WIDTH+1 bits or uses the terminal compare above, so it never wraps early.
- CLEAR_ON_RESET=0: memory array is not initialised by reset (simulation X until written); busy is tied 0 after reset.

Test Plan:
- Clear sequence (ADDR_WIDTH=4):
  - Reset high 2 cycles, then low.
  - busy must be high exactly 16 cycles, then 0.
  - Afterwards, read addresses 0..15 on both ports: every value 0.
- Basic R/W:
  - A writes 16'hBEEF @ 3, B writes 16'h1234 @ 7.
  - Next cycle, A reads 7 and B reads 3.
  - One cycle later: a_q=16'h1234, b_q=16'hBEEF.
- Read-during-write:
  - Pre-load mem[5]=16'h0011.
  - A writes 16'h00AA @ 5 while B reads 5.
  - RDW_MODE=0: a_q=b_q=16'h0011. RDW_MODE=1: a_q=b_q=16'h00AA.
  - Either mode: a later read returns 16'h00AA.
- Collision:
  - A writes 16'h1111 and B writes 16'h2222, both @ 9.
  - collision=1 for exactly one cycle; mem[9] reads back 16'h1111.
  - Both write to 9 and 10 respectively: collision stays 0.
- Reset mid-clear (ADDR_WIDTH=4):
  - Assert reset on clear cycle 8 for 1 cycle.
  - busy must then stay high a further 16 full cycles.
  - a_we=1 during busy has no effect: written location still reads 0.
- CLEAR_ON_RESET=0:
  - Write 16'hCAFE @ 2, pulse reset.
  - busy stays 0; a_q=0 on the reset edge; a read of 2 returns 16'hCAFE.

Source files
------------

// File: rtl/mem_dp.sv
// True dual-port synchronous RAM with selectable read-during-write, port-A-wins
// write arbitration with a collision flag, and an optional post-reset clear sweep.
module mem_dp #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_we,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  busy,
    output logic                  collision
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] a_q_q, a_q_d;
    logic [DATA_WIDTH-1:0] b_q_q, b_q_d;
    logic                  coll_q, coll_d;
    logic                  ready, same_addr, a_wr, b_wr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign busy      = (state_q == CLEAR);
    assign a_q       = a_q_q;
    assign b_q       = b_q_q;
    assign collision = coll_q;

    always_comb begin
        ready     = (state_q == READY);
        same_addr = (a_addr == b_addr);
        a_wr      = ready & a_we;
        b_wr      = ready & b_we;
        coll_d    = a_wr & b_wr & same_addr;

        // Write-first forwarding: port A's data takes precedence on a shared address.
        a_q_d = mem[a_addr];
        b_q_d = mem[b_addr];
        if (RDW_MODE != 0) begin
            if (a_we)                 a_q_d = a_data;
            else if (b_we && same_addr) a_q_d = b_data;
            if (a_we && same_addr)    b_q_d = a_data;
            else if (b_we)            b_q_d = b_data;
        end
        if (!ready) begin
            a_q_d = '0;
            b_q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            a_q_q   <= '0;
            b_q_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            a_q_q  <= a_q_d;
            b_q_q  <= b_q_d;
            coll_q <= coll_d;
            if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_q <= READY;
            end
        end
    end

    // Array has no reset of its own; port A is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= '0;
            end else begin
                if (b_wr) mem[b_addr] <= b_data;
                if (a_wr) mem[a_addr] <= a_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_dp.sv
// Directed bench for mem_dp: three instances (read-first, write-first, no-clear)
// share one stimulus stream and are checked against hand-computed values.
module tb_mem_dp;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_data, b_data;
    logic [3:0]  a_addr, b_addr;
    logic        a_we, b_we;

    logic [15:0] a_q0, b_q0, a_q1, b_q1, a_q2, b_q2;
    logic        busy0, busy1, busy2, col0, col1, col2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .reset(reset),
        .a_data(a_data), .a_addr(a_addr), .a_we(a_we), .a_q(a_q0),
        .b_data(b_data), .b_addr(b_addr), .b_we(b_we), .b_q(b_q0),
        .busy(busy0), .collision(col0));

    mem_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset),
        .a_data(a_data), .a_addr(a_addr), .a_we(a_we), .a_q(a_q1),
        .b_data(b_data), .b_addr(b_addr), .b_we(b_we), .b_q(b_q1),
        .busy(busy1), .collision(col1));

    mem_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .reset(reset),
        .a_data(a_data), .a_addr(a_addr), .a_we(a_we), .a_q(a_q2),
        .b_data(b_data), .b_addr(b_addr), .b_we(b_we), .b_q(b_q2),
        .busy(busy2), .collision(col2));

    typedef struct {
        logic        a_we;
        logic [3:0]  a_addr;
        logic [15:0] a_data;
        logic        b_we;
        logic [3:0]  b_addr;
        logic [15:0] b_data;
        logic [15:0] a0, b0;  // expected, read-first instance
        logic [15:0] a1, b1;  // expected, write-first instance
        logic        col;
        logic        def2;    // no-clear instance holds defined data at both read addresses
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int n;

        //           a_we addr   a_data     b_we addr   b_data     a0        b0        a1        b1        col  def2
        vt[0]  = '{1'b1, 4'd3,  16'hBEEF, 1'b1, 4'd7,  16'h1234, 16'h0000, 16'h0000, 16'hBEEF, 16'h1234, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 4'd7,  16'h0000, 1'b0, 4'd3,  16'h0000, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 4'd5,  16'h0011, 1'b0, 4'd5,  16'h0000, 16'h0000, 16'h0000, 16'h0011, 16'h0011, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 4'd5,  16'h00AA, 1'b0, 4'd5,  16'h0000, 16'h0011, 16'h0011, 16'h00AA, 16'h00AA, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 4'd5,  16'h0000, 1'b0, 4'd5,  16'h0000, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 4'd6,  16'h0000, 1'b1, 4'd6,  16'h0055, 16'h0000, 16'h0000, 16'h0055, 16'h0055, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 4'd9,  16'h1111, 1'b1, 4'd9,  16'h2222, 16'h0000, 16'h0000, 16'h1111, 16'h1111, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 4'd9,  16'h0000, 1'b0, 4'd9,  16'h0000, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 4'd9,  16'h3333, 1'b1, 4'd10, 16'h4444, 16'h1111, 16'h0000, 16'h3333, 16'h4444, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 4'd9,  16'h0000, 1'b0, 4'd10, 16'h0000, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1'b0, 1'b1};
        vt[10] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd0,  16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
        vt[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd15, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b1};

        reset = 1'b1;
        a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        tick();
        tick();
        chk("rst a_q0", a_q0, 0);
        chk("rst b_q0", b_q0, 0);
        chk("rst col0", col0, 0);
        chk("rst busy0", busy0, 1);
        chk("rst busy2", busy2, 0);

        // Clear sweep: count edges until busy drops.
        reset = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
            if (busy2) chk("busy2 during clear", busy2, 0);
        end
        chk("clear length", n, 16);
        chk("busy1 after clear", busy1, 0);

        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            b_addr = 4'(15 - i);
            tick();
            chk($sformatf("clr a_q0[%0d]", i), a_q0, 0);
            chk($sformatf("clr b_q0[%0d]", 15 - i), b_q0, 0);
            chk($sformatf("clr a_q1[%0d]", i), a_q1, 0);
            chk($sformatf("clr b_q1[%0d]", 15 - i), b_q1, 0);
        end

        for (int i = 0; i < 12; i++) begin
            a_we = vt[i].a_we; a_addr = vt[i].a_addr; a_data = vt[i].a_data;
            b_we = vt[i].b_we; b_addr = vt[i].b_addr; b_data = vt[i].b_data;
            tick();
            chk($sformatf("v%0d a_q0", i), a_q0, vt[i].a0);
            chk($sformatf("v%0d b_q0", i), b_q0, vt[i].b0);
            chk($sformatf("v%0d a_q1", i), a_q1, vt[i].a1);
            chk($sformatf("v%0d b_q1", i), b_q1, vt[i].b1);
            chk($sformatf("v%0d col0", i), col0, vt[i].col);
            chk($sformatf("v%0d col1", i), col1, vt[i].col);
            chk($sformatf("v%0d col2", i), col2, vt[i].col);
            if (vt[i].def2) begin
                chk($sformatf("v%0d a_q2", i), a_q2, vt[i].a0);
                chk($sformatf("v%0d b_q2", i), b_q2, vt[i].b0);
            end
        end

        // Contents survive reset on the no-clear instance; a_q zeroed on the reset edge.
        a_we = 1'b1; a_addr = 4'd2; a_data = 16'hCAFE; b_we = 1'b0; b_addr = 4'd2;
        tick();
        a_we = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst-edge a_q2", a_q2, 0);
        chk("rst-edge busy2", busy2, 0);
        chk("rst-edge busy0", busy0, 1);

        // Writes during the sweep must be ignored, including on the write-first instance.
        reset = 1'b0;
        a_we = 1'b1; a_addr = 4'd4; a_data = 16'hDEAD;
        for (int i = 0; i < 8; i++) tick();
        chk("mid-clear busy0", busy0, 1);
        chk("mid-clear a_q1 held", a_q1, 0);
        chk("mid-clear a_q0 held", a_q0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
        end
        chk("restart clear length", n, 16);
        chk("busy1 after restart", busy1, 0);
        chk("busy2 after restart", busy2, 0);

        a_we = 1'b0; a_addr = 4'd4; b_addr = 4'd2;
        tick();
        chk("ignored wr a_q0", a_q0, 0);
        chk("ignored wr a_q1", a_q1, 0);
        chk("cleared b_q0", b_q0, 0);
        chk("kept b_q2", b_q2, 16'hCAFE);
        chk("live wr a_q2", a_q2, 16'hDEAD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
